// File: rtl/cnn_pkg.sv
// Shared conv-datapath definitions: default widths, pipeline tag and tree sizing helpers.
package cnn_pkg;

  localparam int unsigned InWDef   = 16;
  localparam int unsigned BiasWDef = 8;
  localparam int unsigned OutWDef  = 24;
  localparam int unsigned NInDef   = 9;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } psum_tag_t;

  // Number of registered adder levels needed to reduce n products plus the bias leaf.
  function automatic int unsigned tree_depth(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Operand count entering level k of a tree that starts with n leaves.
  function automatic int unsigned level_cnt(input int unsigned n, input int unsigned k);
    int unsigned m;
    m = n;
    for (int unsigned i = 0; i < k; i++) begin
      m = (m + 1) / 2;
    end
    return m;
  endfunction

endpackage

// File: rtl/tree_level.sv
// One registered reduction level: M operands -> ceil(M/2) pairwise sums, tag carried alongside.
module tree_level
  import cnn_pkg::*;
#(
  parameter int unsigned M = 10,
  parameter int unsigned W = 24
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       adv_i,
  input  psum_tag_t                  tag_i,
  input  logic [M*W-1:0]             opnd_i,
  output psum_tag_t                  tag_o,
  output logic [((M+1)/2)*W-1:0]     sum_o
);

  localparam int unsigned H = (M + 1) / 2;

  logic [2*H*W-1:0] opnd_pad;
  logic [H*W-1:0]   sum_d, sum_q;
  psum_tag_t        tag_q;

  // Pad an odd operand count with a zero so the leftover passes straight through.
  always_comb begin
    opnd_pad = '0;
    opnd_pad[M*W-1:0] = opnd_i;
    sum_d = '0;
    for (int unsigned j = 0; j < H; j++) begin
      sum_d[j*W +: W] = opnd_pad[2*j*W +: W] + opnd_pad[(2*j+1)*W +: W];
    end
  end

  // Level register; holds with the rest of the pipe while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      tag_q <= '0;
    end else if (adv_i) begin
      sum_q <= sum_d;
      tag_q <= tag_i;
    end
  end

  assign sum_o = sum_q;
  assign tag_o = tag_q;

endmodule

// File: rtl/psum_accum_tree.sv
// Pipelined partial-sum reduction tree with bias injection, channel accumulation and one
// result per group. Define PSUM_ACCUM_SAT_EN to saturate the accumulator instead of wrapping.
module psum_accum_tree
  import cnn_pkg::*;
#(
  parameter int unsigned IN_W   = InWDef,
  parameter int unsigned BIAS_W = BiasWDef,
  parameter int unsigned OUT_W  = OutWDef,
  parameter int unsigned N_IN   = NInDef
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              in_first_i,
  input  logic              in_last_i,
  input  logic [BIAS_W-1:0] bias_in_i,
  input  logic [IN_W-1:0]   prod_in_i [N_IN],
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [OUT_W-1:0]  out_data_o
);

  localparam int unsigned NLeaf = N_IN + 1;
  localparam int unsigned D     = tree_depth(N_IN);

  logic [NLeaf*OUT_W-1:0] leaves;
  psum_tag_t              in_tag;
  logic                   adv;

  logic [OUT_W-1:0] acc_d, acc_q;
  logic [OUT_W-1:0] out_data_d, out_data_q;
  logic             out_valid_d, out_valid_q;
  logic [OUT_W-1:0] tree_sum, acc_sum, acc_new;
  psum_tag_t        tree_tag;

  // Whole pipe stalls only when a result is waiting and downstream refuses it.
  assign adv        = !(out_valid_q && !out_ready_i);
  assign in_ready_o = adv;

  // Sign-extended leaves; bias only enters on the first beat of a group.
  always_comb begin
    leaves = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      leaves[i*OUT_W +: OUT_W] = OUT_W'($signed(prod_in_i[i]));
    end
    leaves[N_IN*OUT_W +: OUT_W] = in_first_i ? OUT_W'($signed(bias_in_i)) : '0;
    in_tag.valid = in_valid_i;
    in_tag.first = in_first_i;
    in_tag.last  = in_last_i;
  end

  for (genvar k = 0; k < D; k++) begin : g_lvl
    localparam int unsigned Mk = level_cnt(NLeaf, k);
    localparam int unsigned Hk = (Mk + 1) / 2;

    logic [Mk*OUT_W-1:0] opnd;
    logic [Hk*OUT_W-1:0] sum;
    psum_tag_t           tag_in, tag_out;

    if (k == 0) begin : g_src
      assign opnd   = leaves;
      assign tag_in = in_tag;
    end else begin : g_src
      assign opnd   = g_lvl[k-1].sum;
      assign tag_in = g_lvl[k-1].tag_out;
    end

    tree_level #(
      .M (Mk),
      .W (OUT_W)
    ) u_level (
      .clk    (clk),
      .rst_n  (rst_n),
      .adv_i  (adv),
      .tag_i  (tag_in),
      .opnd_i (opnd),
      .tag_o  (tag_out),
      .sum_o  (sum)
    );
  end

  assign tree_sum = g_lvl[D-1].sum;
  assign tree_tag = g_lvl[D-1].tag_out;

`ifdef PSUM_ACCUM_SAT_EN
  logic [OUT_W:0] acc_wide;

  // One extra bit exposes signed overflow; clamp to the representable range.
  always_comb begin
    acc_wide = {acc_q[OUT_W-1], acc_q} + {tree_sum[OUT_W-1], tree_sum};
    if (acc_wide[OUT_W] != acc_wide[OUT_W-1]) begin
      acc_sum = acc_wide[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end else begin
      acc_sum = acc_wide[OUT_W-1:0];
    end
  end
`else
  // Modulo-2^OUT_W accumulation.
  always_comb begin
    acc_sum = acc_q + tree_sum;
  end
`endif

  // Accumulate on valid tree output; a last beat publishes the sum and reopens from zero.
  always_comb begin
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    acc_new     = tree_tag.first ? tree_sum : acc_sum;
    if (adv) begin
      out_valid_d = tree_tag.valid && tree_tag.last;
      if (tree_tag.valid) begin
        acc_d = tree_tag.last ? '0 : acc_new;
        if (tree_tag.last) begin
          out_data_d = acc_new;
        end
      end
    end
  end

  // Accumulator and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule

// File: tb/tb_psum_accum_tree.sv
// Directed bench for psum_accum_tree at default parameters; results are scoreboarded in order.
module tb_psum_accum_tree;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, in_first, in_last;
  logic [7:0]  bias;
  logic [15:0] prod [9];
  logic        out_valid, out_ready;
  logic [23:0] out_data;

  int     n_checks = 0;
  int     n_errors = 0;
  int     n_out    = 0;
  int     n_pushed = 0;
  longint exp_q [$];

  psum_accum_tree u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_first_i  (in_first),
    .in_last_i   (in_last),
    .bias_in_i   (bias),
    .prod_in_i   (prod),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input longint v);
    exp_q.push_back(v);
    n_pushed++;
  endtask

  // Present one beat for one cycle; prod[i] = base + i*inc.
  task automatic beat(input logic f, input logic l, input int base, input int inc, input int b);
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
    bias     = 8'(b);
    for (int i = 0; i < 9; i++) prod[i] = 16'(base + i * inc);
    chk("in_ready_on_beat", in_ready, 1);
    step();
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    if (lat >= 20) chk("out_valid_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Scoreboard: every completed output handshake must match the next expected result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) chk("extra_out", n_out, n_pushed);
      else chk("out_data", $signed(out_data), exp_q.pop_front());
    end
  end

  initial begin
    int     lat;
    int     base_out;
    longint sat_exp;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    bias      = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) prod[i] = '0;
    idle(2);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    step();

    // Single-beat group: 1..9 plus bias -5, five-cycle latency, one pulse.
    push(40);
    beat(1, 1, 1, 1, -5);
    wait_out(lat);
    chk("t1_latency", lat + 1, 5);
    step();
    chk("t1_single_pulse", out_valid, 0);

    // Three-beat group, prod=2, bias=3.
    base_out = n_out;
    push(57);
    beat(1, 0, 2, 0, 3);
    beat(0, 0, 2, 0, 3);
    beat(0, 1, 2, 0, 3);
    idle(10);
    chk("t2_one_output", n_out - base_out, 1);

    // Second first beat restarts the group: 9*1 + 4.
    push(13);
    beat(1, 0, 100, 0, 0);
    beat(1, 1, 1, 0, 4);
    idle(8);

    // Back-to-back single-beat groups: prod[i]=k+i, bias=k -> 10k+36.
    base_out = n_out;
    for (int k = 1; k <= 8; k++) begin
      push(10 * k + 36);
      beat(1, 1, k, 1, k);
    end
    idle(8);
    chk("t3_count", n_out - base_out, 8);

    // Stall with the pipe full.
    base_out  = n_out;
    out_ready = 1'b0;
    for (int k = 20; k < 25; k++) begin
      push(10 * k + 36);
      beat(1, 1, k, 1, k);
    end
    wait_out(lat);
    for (int c = 0; c < 4; c++) begin
      chk("t4_in_ready_low", in_ready, 0);
      chk("t4_valid_held", out_valid, 1);
      chk("t4_data_held", $signed(out_data), exp_q[0]);
      step();
    end
    out_ready = 1'b1;
    idle(12);
    chk("t4_count", n_out - base_out, 5);

    // Long accumulation: 30 beats of 9 x 32767.
`ifdef PSUM_ACCUM_SAT_EN
    sat_exp = 8388607;
`else
    sat_exp = -7930126;
`endif
    push(sat_exp);
    for (int b = 0; b < 30; b++) beat(b == 0, b == 29, 32767, 0, 0);
    idle(8);

    // Mid-group reset.
    out_ready = 1'b0;
    beat(1, 1, 1, 0, 0);
    beat(1, 0, 100, 0, 0);
    wait_out(lat);
    chk("t6_pre_rst_data", $signed(out_data), 9);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_data", out_data, 0);
    chk("t6_rst_in_ready", in_ready, 1);
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();
    push(9);
    beat(0, 1, 1, 0, 50);
    push(25);
    beat(1, 1, 3, 0, -2);
    idle(10);

    chk("drain_empty", exp_q.size(), 0);
    chk("total_outputs", n_out, n_pushed);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
